aes_sbox_out_stage: RTL
=======================

Name: aes_sbox_out_stage

Overview:
- Registered output stage of the 3-share (second-order) masked S-box; sits directly downstream of the output linear map.
- Consumes the three mapped shares, folds the S-box affine constant into the data share only, and re-randomises the masks with fresh PRD.
- Buffers results in a small elastic FIFO with valid/ready handshakes, so SubBytes/round logic can stall without combinational paths back into the S-box.

Parameters:
- Depth, 2, FIFO entries; power of two, >= 2.
- AffineConst, 8'h63, constant XORed into the data share only.
- RefreshEn, 1, 1 = apply PRD mask refresh; 0 = ignore prd_i (PRD handshake still required).

Ports:
- clk_i  input  1  clock
- rst_i  input  1  asynchronous active-high reset
- in_valid_i  input  1  shares on data/mask inputs valid
- in_ready_o  output  1  stage can accept (registered, = count < Depth)
- data_i  input  8  share 0 from linear map
- mask0_i  input  8  share 1
- mask1_i  input  8  share 2
- prd_valid_i  input  1  fresh randomness available
- prd_i  input  16  [7:0] = r0, [15:8] = r1
- prd_ack_o  output  1  PRD consumed this cycle (= accept)
- out_valid_o  output  1  head entry valid
- out_ready_i  input  1  consumer takes head entry
- data_o  output  8  share 0 of S-box result
- mask0_o  output  8  share 1
- mask1_o  output  8  share 2
- flush_i  input  1  synchronous clear of all entries
- count_o  output  $clog2(Depth)+1  occupancy

Behaviour:
- Reset (async, rst_i=1): all storage, pointers and count cleared to 0; in_ready_o=1; out_valid_o=0; prd_ack_o=0; data_o/mask0_o/mask1_o=0.
- Accept: accept = in_valid_i & in_ready_o & prd_valid_i & ~flush_i.
  - prd_valid_i low stalls the input; it never drops data.
  - prd_ack_o = accept (combinational from inputs; no other path).
- Stored on accept:
  - d' = data_i ^ AffineConst ^ r0 ^ r1
  - m0' = mask0_i ^ r0
  - m1' = mask1_i ^ r1
  - With RefreshEn=0, r0 = r1 = 0.
  - The unmasked value (XOR of the three shares) equals the input XOR ^ AffineConst.
  - The three shares are never combined with each other. Each share has its own register slice.
- Latency:
  - 1 cycle from accept to out_valid_o when empty.
  - No combinational input-to-output pass-through.
- Pop: pop = out_valid_o & out_ready_i. Head advances next cycle.
- Outputs:
  - Driven from the head entry when count > 0.
  - Forced to 0 when empty, so stale shares are never exposed.
- Full (count == Depth):
  - in_ready_o = 0, including in a cycle with a simultaneous pop.
  - in_ready_o rises the cycle after the pop.
- Simultaneous accept and pop (0 < count < Depth): count unchanged; both pointers advance.
- Pointers wrap modulo Depth. count saturates by construction; never exceeds Depth or underflows.
- flush_i:
  - Next cycle: count=0, pointers=0, all entries zeroed.
  - flush_i has priority over accept and pop.
  - prd_ack_o=0 in a flush cycle.
- Reset asserted mid-operation: contents are lost and outputs return to reset values immediately (async); no partial entry survives.
- X-safety: an X on data/mask/prd inputs with accept=0 must not affect state.

Decomposition:
- Shared package aes_masked_pkg holds:
  - typedef sbox_shares_t (packed struct: data, mask0, mask1, each 8 bits)
  - typedef prd_sbox_t (r0, r1)
  - constant AES_SBOX_AFFINE_CONST = 8'h63
- One sub-module, aes_share_fifo: parameterised Depth entries of sbox_shares_t, with push/pop/flush, a count output, and a zero-on-empty read port.
- The top level handles affine folding, refresh and the PRD handshake.

Test Plan:
- Basic affine: data=0x00, mask0=0x00, mask1=0x00, prd=0x0000, accept at cycle 0 -> cycle 1: out_valid_o=1, data_o=0x63, mask0_o=0x00, mask1_o=0x00, count_o=1.
- Refresh: data=0x12, mask0=0x34, mask1=0x56, prd=0x55AA (r0=0xAA, r1=0x55) -> data_o=0x8E, mask0_o=0x9E, mask1_o=0x03; XOR of shares = 0x13. With RefreshEn=0 -> 0x71, 0x34, 0x56.
- PRD stall: in_valid_i=1, prd_valid_i=0 for 3 cycles -> prd_ack_o=0, count_o=0, outputs 0; prd_valid_i=1 on cycle 3 -> accepted, output valid on cycle 4.
- Full and backpressure: push 3 back-to-back with out_ready_i=0, Depth=2.
  - in_ready_o=0 once count_o=2; the third item is held.
  - out_ready_i=1 for one cycle -> first item popped in order; in_ready_o=1 the next cycle; third item accepted.
  - Data order preserved.
- Simultaneous push/pop at count=1 for 10 cycles with incrementing data 0x00..0x09 and prd=0 -> count_o stays 1; outputs 0x63^k in order.
- Flush and reset: count=2, assert flush_i together with in_valid_i -> next cycle count_o=0, outputs 0, prd_ack_o was 0. Then fill 1 entry, assert rst_i mid-cycle -> outputs 0 and in_ready_o=1 without waiting for a clock edge.

Source files
------------

// File: rtl/aes_masked_pkg.sv
// Shared types and constants for the masked AES S-box datapath.
//   sbox_shares_t          : the three Boolean shares of one S-box byte
//   prd_sbox_t             : fresh randomness for one refresh; the bit layout
//                            matches prd_i ({r1, r0})
//   AES_SBOX_AFFINE_CONST  : affine constant of the S-box output map
package aes_masked_pkg;

    typedef struct packed {
        logic [7:0] data;
        logic [7:0] mask0;
        logic [7:0] mask1;
    } sbox_shares_t;

    typedef struct packed {
        logic [7:0] r1;
        logic [7:0] r0;
    } prd_sbox_t;

    localparam logic [7:0] AES_SBOX_AFFINE_CONST = 8'h63;

endpackage

// File: rtl/aes_share_fifo.sv
// Small elastic FIFO holding masked S-box results.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_push/i_din : write one entry (caller guarantees not full)
//   i_pop        : drop the head entry (caller guarantees not empty)
//   i_flush      : synchronous clear; wins over push and pop
//   o_dout       : head entry, all-zero when empty
//   o_count      : occupancy, 0..Depth
//   o_full       : count == Depth
module aes_share_fifo
    import aes_masked_pkg::*;
#(
    parameter int Depth = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_push,
    input  sbox_shares_t               i_din,
    input  logic                       i_pop,
    input  logic                       i_flush,
    output sbox_shares_t               o_dout,
    output logic [$clog2(Depth):0]     o_count,
    output logic                       o_full
);

    localparam int PW = $clog2(Depth);
    localparam int CW = PW + 1;

    sbox_shares_t      r_mem [Depth];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            // Zero the storage too so no old share lingers in a register.
            for (int i = 0; i < Depth; i++) r_mem[i] <= '0;
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            // Storage is only written on push, so X on the data inputs
            // while idle never reaches state.
            if (i_push) begin
                r_mem[r_wptr] <= i_din;
                r_wptr        <= r_wptr + PW'(1);
            end
            if (i_pop) r_rptr <= r_rptr + PW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Empty FIFO shows zero shares rather than whatever sits at the head.
    assign o_dout  = (r_count != '0) ? r_mem[r_rptr] : '0;
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(Depth));

endmodule

// File: rtl/aes_sbox_out_stage.sv
// Registered output stage of the 3-share masked S-box.
// Folds the affine constant into the data share, re-randomises both masks
// with fresh PRD and buffers the result in an elastic FIFO.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   in_valid_i / in_ready_o      : input handshake (ready = not full)
//   data_i, mask0_i, mask1_i     : input shares from the linear map
//   prd_valid_i, prd_i, prd_ack_o: PRD handshake; ack == accept
//   out_valid_o / out_ready_i    : output handshake
//   data_o, mask0_o, mask1_o     : output shares (zero when empty)
//   flush_i                      : synchronous clear of all entries
//   count_o                      : occupancy
module aes_sbox_out_stage
    import aes_masked_pkg::*;
#(
    parameter int         Depth       = 2,
    parameter logic [7:0] AffineConst = AES_SBOX_AFFINE_CONST,
    parameter bit         RefreshEn   = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    in_valid_i,
    output logic                    in_ready_o,
    input  logic [7:0]              data_i,
    input  logic [7:0]              mask0_i,
    input  logic [7:0]              mask1_i,
    input  logic                    prd_valid_i,
    input  logic [15:0]             prd_i,
    output logic                    prd_ack_o,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [7:0]              data_o,
    output logic [7:0]              mask0_o,
    output logic [7:0]              mask1_o,
    input  logic                    flush_i,
    output logic [$clog2(Depth):0]  count_o
);

    prd_sbox_t    w_prd;
    logic [7:0]   w_r0;
    logic [7:0]   w_r1;
    logic         w_full;
    logic         w_accept;
    logic         w_pop;
    sbox_shares_t w_push_shares;
    sbox_shares_t w_head;

    assign w_prd = prd_sbox_t'(prd_i);
    assign w_r0  = RefreshEn ? w_prd.r0 : 8'h00;
    assign w_r1  = RefreshEn ? w_prd.r1 : 8'h00;

    // in_ready_o comes straight from the registered count, so a pop in a
    // full cycle only frees a slot from the next cycle on.
    assign in_ready_o  = ~w_full;
    assign out_valid_o = (count_o != '0);

    assign w_accept  = in_valid_i & in_ready_o & prd_valid_i & ~flush_i;
    assign w_pop     = out_valid_o & out_ready_i & ~flush_i;
    assign prd_ack_o = w_accept;

    // Each share is refreshed on its own; r0 ^ r1 goes into the data share
    // so the unmasked value only picks up the affine constant.
    assign w_push_shares.data  = data_i  ^ AffineConst ^ w_r0 ^ w_r1;
    assign w_push_shares.mask0 = mask0_i ^ w_r0;
    assign w_push_shares.mask1 = mask1_i ^ w_r1;

    aes_share_fifo #(.Depth(Depth)) u_fifo (
        .i_clk   (clk_i),
        .i_rst   (rst_i),
        .i_push  (w_accept),
        .i_din   (w_push_shares),
        .i_pop   (w_pop),
        .i_flush (flush_i),
        .o_dout  (w_head),
        .o_count (count_o),
        .o_full  (w_full)
    );

    assign data_o  = w_head.data;
    assign mask0_o = w_head.mask0;
    assign mask1_o = w_head.mask1;

endmodule
